serial_mod_detector: RTL and testbench

//   Parametrised serial divisibility checker: accepts a bit stream one bit per

---
 rtl/serial_mod_pkg.sv | 14 +
 rtl/serial_mod_detector_mod_step.sv | 39 +++
 rtl/serial_mod_detector.sv | 145 ++++++++++++++
 tb/tb_serial_mod_detector.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_mod_pkg.sv
// Shared definitions for the serial modulus detector: FSM encoding and width helper.
package serial_mod_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_mod_detector_mod_step.sv
// One-bit remainder update for the serial modulus detector.
// LSB_FIRST_EN selects the weighted LSB-first step; otherwise the MSB-first shift-in step.
module mod_step
    import serial_mod_pkg::*;
#(
    parameter  int DIVISOR = 3,
    localparam int RW      = width_of(DIVISOR)
) (
    input  logic [RW-1:0] i_rem,
    input  logic          i_bit,
`ifdef LSB_FIRST_EN
    input  logic [RW-1:0] i_w,
    output logic [RW-1:0] o_w,
`endif
    output logic [RW-1:0] o_rem
);

    localparam logic [RW:0] D_T = (RW+1)'(DIVISOR);

    logic [RW:0] w_t;

`ifdef LSB_FIRST_EN
    logic [RW:0] w_w2;

    // Both rem+w and 2w stay below 2*DIVISOR, so one subtract each suffices.
    always_comb begin
        w_t   = {1'b0, i_rem} + (i_bit ? {1'b0, i_w} : '0);
        o_rem = RW'((w_t >= D_T) ? (w_t - D_T) : w_t);
        w_w2  = {i_w, 1'b0};
        o_w   = RW'((w_w2 >= D_T) ? (w_w2 - D_T) : w_w2);
    end
`else
    always_comb begin
        w_t   = {i_rem, i_bit};
        o_rem = RW'((w_t >= D_T) ? (w_t - D_T) : w_t);
    end
`endif

endmodule

// File: rtl/serial_mod_detector.sv
// Framed serial divisibility checker: running remainder modulo DIVISOR, one result per word.
// Define LSB_FIRST_EN for an LSB-first stream (adds a weight register); default is MSB first.
module serial_mod_detector
    import serial_mod_pkg::*;
#(
    parameter  int DIVISOR  = 3,
    parameter  int MAX_BITS = 32,
    localparam int RW       = width_of(DIVISOR),
    localparam int CW       = width_of(MAX_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_bit,
    input  logic          in_sof,
    input  logic          in_last,
    output logic          div_now,
    output logic [RW-1:0] rem,
    output logic          res_valid,
    output logic          res_div,
    output logic [CW-1:0] res_len,
    output logic          ovf
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_BITS);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;
    logic [RW-1:0] r_rem;
    logic [RW-1:0] w_rem_base;
    logic [RW-1:0] w_rem_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ovf_nxt;
    logic          r_div_now;
    logic          r_res_valid;
    logic          r_res_div;
    logic [CW-1:0] r_res_len;
    logic          r_ovf;

`ifdef LSB_FIRST_EN
    logic [RW-1:0] r_w;
    logic [RW-1:0] w_w_base;
    logic [RW-1:0] w_w_nxt;
`endif

    // A start bit is taken from either state; other bits only extend an open word.
    always_comb begin
        w_accept    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    w_accept    = 1'b1;
                    w_state_nxt = in_last ? IDLE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = in_last ? IDLE : ACC;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rem_base = in_sof ? '0 : r_rem;
        w_cnt_nxt  = in_sof ? CW'(1) : ((r_cnt == MAX_C) ? r_cnt : r_cnt + CW'(1));
        w_ovf_nxt  = in_sof ? 1'b0 : (r_ovf | (r_cnt == MAX_C));
    end

`ifdef LSB_FIRST_EN
    assign w_w_base = in_sof ? RW'(1) : r_w;

    mod_step #(.DIVISOR(DIVISOR)) u_step (
        .i_rem (w_rem_base),
        .i_bit (in_bit),
        .i_w   (w_w_base),
        .o_w   (w_w_nxt),
        .o_rem (w_rem_nxt)
    );
`else
    mod_step #(.DIVISOR(DIVISOR)) u_step (
        .i_rem (w_rem_base),
        .i_bit (in_bit),
        .o_rem (w_rem_nxt)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // div_now also reflects the closing bit for the cycle its result is shown.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_div_now   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_div   <= 1'b0;
            r_res_len   <= '0;
        end else begin
            r_res_valid <= w_accept && in_last;
            if (w_accept) begin
                r_rem     <= w_rem_nxt;
                r_cnt     <= w_cnt_nxt;
                r_ovf     <= w_ovf_nxt;
                r_div_now <= (w_rem_nxt == '0);
                if (in_last) begin
                    r_res_div <= (w_rem_nxt == '0);
                    r_res_len <= w_cnt_nxt;
                end
            end else if (r_state == IDLE) begin
                r_div_now <= 1'b0;
            end
        end
    end

`ifdef LSB_FIRST_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w <= RW'(1);
        end else if (w_accept) begin
            r_w <= w_w_nxt;
        end
    end
`endif

    assign div_now   = r_div_now;
    assign rem       = r_rem;
    assign res_valid = r_res_valid;
    assign res_div   = r_res_div;
    assign res_len   = r_res_len;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_mod_detector.sv
// Directed bench for serial_mod_detector: D=3, D=4 and MAX_BITS=4 instances share one stimulus.
module tb_serial_mod_detector;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_bit, in_sof, in_last;

    logic       a_dn, a_rv, a_rd, a_ovf;
    logic [1:0] a_rem;
    logic [5:0] a_rl;
    logic       b_dn, b_rv, b_rd, b_ovf;
    logic [1:0] b_rem;
    logic [5:0] b_rl;
    logic       c_dn, c_rv, c_rd, c_ovf;
    logic [1:0] c_rem;
    logic [2:0] c_rl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_mod_detector #(.DIVISOR(3), .MAX_BITS(32)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .in_last(in_last), .div_now(a_dn), .rem(a_rem), .res_valid(a_rv),
        .res_div(a_rd), .res_len(a_rl), .ovf(a_ovf));

    serial_mod_detector #(.DIVISOR(4), .MAX_BITS(32)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .in_last(in_last), .div_now(b_dn), .rem(b_rem), .res_valid(b_rv),
        .res_div(b_rd), .res_len(b_rl), .ovf(b_ovf));

    serial_mod_detector #(.DIVISOR(3), .MAX_BITS(4)) dut3s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .in_last(in_last), .div_now(c_dn), .rem(c_rem), .res_valid(c_rv),
        .res_div(c_rd), .res_len(c_rl), .ovf(c_ovf));

    typedef struct {
        logic       v, b, s, l;
        logic [1:0] rem;
        logic       dn, rv, rd;
        logic [5:0] rl;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic s, input logic l);
        in_valid = v;
        in_bit   = b;
        in_sof   = s;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.rem", 32'(a_rem), 0);
        chk("rst.div_now", 32'(a_dn), 0);
        chk("rst.res_valid", 32'(a_rv), 0);
        chk("rst.res_div", 32'(a_rd), 0);
        chk("rst.res_len", 32'(a_rl), 0);
        chk("rst.ovf", 32'(a_ovf), 0);
        rst = 1'b1;

`ifndef LSB_FIRST_EN
        //          v     b     s     l     rem   dn    rv    rd    rl
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 6'd3};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6'd3};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 6'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 6'd3};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 6'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 6'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 6'd3};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 6'd3};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 6'd3};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 6'd3};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 6'd3};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 6'd2};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 6'd2};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 6'd2};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 6'd2};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 6'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6'd1};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 6'd1};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 6'd1};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].l);
            chk($sformatf("row%0d.rem", i), 32'(a_rem), 32'(tbl[i].rem));
            chk($sformatf("row%0d.div_now", i), 32'(a_dn), 32'(tbl[i].dn));
            chk($sformatf("row%0d.res_valid", i), 32'(a_rv), 32'(tbl[i].rv));
            chk($sformatf("row%0d.res_div", i), 32'(a_rd), 32'(tbl[i].rd));
            chk($sformatf("row%0d.res_len", i), 32'(a_rl), 32'(tbl[i].rl));
        end

        // D=4, word 10100 (20): remainders 1,2,1,2,0
        step(1'b1, 1'b1, 1'b1, 1'b0); chk("d4.b0.dn", 32'(b_dn), 0); chk("d4.b0.rem", 32'(b_rem), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); chk("d4.b1.dn", 32'(b_dn), 0); chk("d4.b1.rem", 32'(b_rem), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0); chk("d4.b2.dn", 32'(b_dn), 0); chk("d4.b2.rem", 32'(b_rem), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); chk("d4.b3.dn", 32'(b_dn), 0); chk("d4.b3.rem", 32'(b_rem), 2);
        step(1'b1, 1'b0, 1'b0, 1'b1); chk("d4.b4.dn", 32'(b_dn), 1); chk("d4.b4.rem", 32'(b_rem), 0);
        chk("d4.res_valid", 32'(b_rv), 1);
        chk("d4.res_div", 32'(b_rd), 1);
        chk("d4.res_len", 32'(b_rl), 5);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("d4.idle.dn", 32'(b_dn), 0);
        chk("d4.idle.res_valid", 32'(b_rv), 0);
`else
        // LSB first, D=3: bits 0,1,1 = 6
        step(1'b1, 1'b0, 1'b1, 1'b0); chk("lsb.b0.rem", 32'(a_rem), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0); chk("lsb.b1.rem", 32'(a_rem), 2);
        step(1'b1, 1'b1, 1'b0, 1'b1); chk("lsb.b2.rem", 32'(a_rem), 0);
        chk("lsb.res_valid", 32'(a_rv), 1);
        chk("lsb.res_div", 32'(a_rd), 1);
        chk("lsb.res_len", 32'(a_rl), 3);
        // LSB first, D=3: bits 1,0,1 = 5
        step(1'b1, 1'b1, 1'b1, 1'b0); chk("lsb5.b0.rem", 32'(a_rem), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); chk("lsb5.b1.rem", 32'(a_rem), 1);
        step(1'b1, 1'b1, 1'b0, 1'b1); chk("lsb5.b2.rem", 32'(a_rem), 2);
        chk("lsb5.res_div", 32'(a_rd), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lsb5.idle.res_valid", 32'(a_rv), 0);
`endif

        // MAX_BITS=4, six-bit word 110000 (48)
        step(1'b1, 1'b1, 1'b1, 1'b0); chk("sat.b0.ovf", 32'(c_ovf), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0); chk("sat.b1.ovf", 32'(c_ovf), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0); chk("sat.b2.ovf", 32'(c_ovf), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0); chk("sat.b3.ovf", 32'(c_ovf), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0); chk("sat.b4.ovf", 32'(c_ovf), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1); chk("sat.b5.ovf", 32'(c_ovf), 1);
        chk("sat.res_valid", 32'(c_rv), 1);
        chk("sat.res_len", 32'(c_rl), 4);
        chk("sat.res_div", 32'(c_rd), 1);
        chk("nosat.res_len", 32'(a_rl), 6);
        chk("nosat.ovf", 32'(a_ovf), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0); chk("sat.sof.ovf", 32'(c_ovf), 0);

        // Reset mid-word, then a stray last bit must not produce a result
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.rem", 32'(a_rem), 0);
        chk("mrst.div_now", 32'(a_dn), 0);
        chk("mrst.res_valid", 32'(a_rv), 0);
        chk("mrst.res_div", 32'(a_rd), 0);
        chk("mrst.res_len", 32'(a_rl), 0);
        chk("mrst.ovf", 32'(c_ovf), 0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mrst.last.res_valid", 32'(a_rv), 0);
        chk("mrst.last.rem", 32'(a_rem), 0);
        chk("mrst.last.res_len", 32'(a_rl), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.after.res_valid", 32'(a_rv), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
